apb_master: RTL and testbench
=============================

// Module: apb_master
// PURPOSE
//  APB requester that issues one transfer at a time toward apb_slave.
//  Accepts a simple valid/ready command (write or read, addr, wdata).
//  Sequences it through the APB SETUP/ACCESS phases, waits for pready_i,
//  then returns a one-cycle response with the read data.
//  Sits between on-chip control logic and the APB register slave.
// PARAMETERS
//  ADDR_W          4   APB address width (matches apb_slave paddr)
//  DATA_W          32  APB data width
//  TIMEOUT_CYCLES  16  ACCESS cycles without pready_i before abort (TIMEOUT_EN only)
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  reset       in   1       synchronous, active-low reset (0 = reset)
//  cmd_valid   in   1       command request
//  cmd_ready   out  1       command accepted when cmd_valid & cmd_ready
//  cmd_write   in   1       1 = write, 0 = read
//  cmd_addr    in   ADDR_W  transfer address
//  cmd_wdata   in   DATA_W  write data (ignored for reads)
//  rsp_valid   out  1       one-cycle pulse: transfer complete
//  rsp_rdata   out  DATA_W  read data, valid with rsp_valid; 0 for writes
//  rsp_err     out  1       timeout abort flag, valid with rsp_valid
//  psel_o      out  1       APB select
//  penable_o   out  1       APB enable
//  pwrite_o    out  1       APB direction
//  paddr_o     out  ADDR_W  APB address
//  pwdata_o    out  DATA_W  APB write data
//  prdata_i    in   DATA_W  APB read data
//  pready_i    in   1       APB ready from the slave
// BEHAVIOUR
//  - Reset (reset==0 at a posedge): state IDLE. All outputs 0, except cmd_ready=1.
//    Any in-flight transfer is abandoned and no rsp_valid is issued.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE. All outputs are registered.
//  - IDLE: cmd_ready=1, psel_o=0, penable_o=0. On cmd_valid, capture cmd_* into
//    paddr_o/pwrite_o/pwdata_o and go to SETUP; cmd_ready drops the same edge.
//  - SETUP (exactly 1 cycle): psel_o=1, penable_o=0. pready_i is ignored.
//    Next state is ACCESS.
//  - ACCESS: psel_o=1, penable_o=1. paddr/pwrite/pwdata are held stable.
//    On pready_i=1: capture prdata_i if read (0 if write), pulse rsp_valid,
//    drop psel/penable, return to IDLE.
//  - Minimum transfer is 3 cycles from acceptance to rsp_valid (pready_i high
//    on the first ACCESS cycle). Each wait cycle adds one.
//  - Next command is accepted no earlier than the rsp_valid cycle + 1
//    (cmd_ready is 1 again in IDLE). There is no pipelining or back-to-back.
//  - cmd_valid while cmd_ready=0 is not captured; the requester holds it.
//  - pwdata_o/paddr_o keep their last values in IDLE; only psel/penable return to 0.
// CONFIGURATION
//  - APB_MASTER_TIMEOUT_EN defined:
//    - Wait counter clears on entry to ACCESS and counts ACCESS cycles with pready_i=0.
//    - When the count reaches TIMEOUT_CYCLES: abort, rsp_valid=1, rsp_err=1,
//      rsp_rdata=0, psel/penable drop, go to IDLE.
//    - pready_i in the abort cycle is ignored.
//  - Not defined: no counter; ACCESS waits indefinitely; rsp_err is tied to 0.
// STRUCTURE
//  - Package apb_master_pkg: typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
//    localparam defaults for ADDR_W/DATA_W.
//  - Single module, no sub-modules. The timeout counter is inline, under `ifdef.
// TESTING
//  1. Write, zero wait: cmd addr=4'h3 wdata=32'h0000_A5A5, pready_i=1
//     -> SETUP at +1, ACCESS at +2, rsp_valid at +3, rsp_err=0, rsp_rdata=0.
//  2. Read, 4 wait states: addr=4'hF, pready_i low 4 ACCESS cycles, prdata_i=32'h1234_5678
//     -> psel/penable/paddr stable; rsp_valid at +7 with rsp_rdata=32'h1234_5678.
//  3. cmd_valid held high over 10 random writes (waits 0..10)
//     -> each cmd accepted only in IDLE; exactly 10 rsp_valid pulses.
//     -> slave model reads back every written value.
//  4. Reset during ACCESS with pready_i=0 -> next cycle all outputs 0, cmd_ready=1,
//     no rsp_valid.
//  5. TIMEOUT_EN, TIMEOUT_CYCLES=16, pready_i stuck 0
//     -> rsp_valid=1, rsp_err=1 after 16 ACCESS cycles.
//     -> without the macro, still waiting at cycle 100.
//  6. pready_i=1 during SETUP only -> ignored; ACCESS still entered; transfer ends
//     only on pready_i during ACCESS.

Source files
------------

// File: rtl/apb_master_pkg.sv
// apb_master_pkg: FSM state type and default bus widths shared by apb_master.
package apb_master_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
  localparam int APB_ADDR_W = 4;
  localparam int APB_DATA_W = 32;
endpackage

// File: rtl/apb_master.sv
// apb_master: one-at-a-time APB requester with a valid/ready command and a one-cycle response.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYCLES cycles.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
`ifdef APB_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);
  apb_state_t state;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: if (cmd_valid) begin
          paddr_o   <= cmd_addr;
          pwrite_o  <= cmd_write;
          pwdata_o  <= cmd_wdata;
          psel_o    <= 1'b1;
          cmd_ready <= 1'b0;
          state     <= SETUP;
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
        end
        ACCESS: begin
          if (pready_i) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite_o ? '0 : prdata_i;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          // the stalled cycle that brings the count to TIMEOUT_CYCLES ends the transfer
          else if (wait_cnt == CNT_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: vector table, hand-written corner sequences and a randomized write/readback burst.
module tb_apb_master;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel_o, penable_o, pwrite_o;
  logic [3:0]  paddr_o;
  logic [31:0] pwdata_o, prdata_i;
  logic        pready_i;

  int n_chk = 0;
  int n_fail = 0;
  int rsp_cnt = 0;
  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          waits;
    bit          setup_rdy;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;
  vec_t vecs [7];

  apb_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reset && rsp_valid) rsp_cnt <= rsp_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issues one command from an IDLE cycle and plays the slave; n counts cycles after acceptance.
  task automatic xfer(input logic wr, input logic [3:0] a, input logic [31:0] wd, input int waits,
                      input bit setup_rdy, input bit hold, input int max_n,
                      output bit got, output int lat, output logic [31:0] rd, output logic er);
    got = 0; lat = 0; rd = '0; er = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; pready_i = 1'b0;
    for (int n = 1; n <= max_n; n++) begin
      @(posedge clk); #1;
      if (hold) begin
        cmd_addr = 4'($urandom); cmd_wdata = $urandom; cmd_write = 1'($urandom);
      end else cmd_valid = 1'b0;
      if (rsp_valid) begin
        got = 1; lat = n; rd = rsp_rdata; er = rsp_err;
        chk("rsp_cycle_ready", 64'(cmd_ready), 64'd1);
        chk("rsp_cycle_psel_penable", 64'({psel_o, penable_o}), 64'd0);
        break;
      end
      chk("busy_ready", 64'(cmd_ready), 64'd0);
      chk("psel", 64'(psel_o), 64'd1);
      chk("penable", 64'(penable_o), 64'(n >= 2));
      chk("paddr", 64'(paddr_o), 64'(a));
      chk("pwrite", 64'(pwrite_o), 64'(wr));
      if (wr) chk("pwdata", 64'(pwdata_o), 64'(wd));
      pready_i = (n == 1) ? setup_rdy : (n - 2 >= waits);
      prdata_i = pready_i ? slv_mem[paddr_o] : $urandom;
      if (n >= 2 && pready_i && pwrite_o) slv_mem[paddr_o] = pwdata_o;
    end
    pready_i = 1'b0;
    if (!hold) cmd_valid = 1'b0;
  endtask

  bit got;
  int lat, w, c0;
  logic [31:0] rd, d;
  logic er;
  logic [3:0] a;

  initial begin
    for (int i = 0; i < 16; i++) slv_mem[i] = '0;
    slv_mem[15] = 32'h1234_5678;
    vecs[0] = '{1'b1, 4'h3, 32'h0000_A5A5, 0, 1'b0, 32'h0, 3};
    vecs[1] = '{1'b0, 4'hF, 32'h0, 4, 1'b0, 32'h1234_5678, 7};
    vecs[2] = '{1'b0, 4'h3, 32'h0, 0, 1'b0, 32'h0000_A5A5, 3};
    vecs[3] = '{1'b1, 4'h7, 32'hDEAD_BEEF, 2, 1'b1, 32'h0, 5};
    vecs[4] = '{1'b0, 4'h7, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 4};
    vecs[5] = '{1'b1, 4'h0, 32'hFFFF_FFFF, 0, 1'b1, 32'h0, 3};
    vecs[6] = '{1'b0, 4'h0, 32'h0, 3, 1'b0, 32'hFFFF_FFFF, 6};

    reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata_i = '0; pready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(cmd_ready), 64'd1);
    chk("reset_outs", 64'({rsp_valid, rsp_err, psel_o, penable_o, pwrite_o, paddr_o}), 64'd0);
    chk("reset_data", {rsp_rdata, pwdata_o}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].setup_rdy, 1'b0, 50,
           got, lat, rd, er);
      chk($sformatf("vec%0d_got", i), 64'(got), 64'd1);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_err", i), 64'(er), 64'd0);
      @(posedge clk); #1;
    end

    // idle keeps address/data, drops select
    chk("idle_hold_paddr", 64'(paddr_o), 64'h0);
    chk("idle_psel", 64'({psel_o, penable_o, rsp_valid}), 64'd0);

    // reset in the middle of a stalled ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h5; cmd_wdata = 32'h5555_AAAA;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_access", 64'({psel_o, penable_o}), 64'd3);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midreset_ready", 64'(cmd_ready), 64'd1);
    chk("midreset_outs", 64'({rsp_valid, rsp_err, psel_o, penable_o, pwrite_o, paddr_o}), 64'd0);
    chk("midreset_data", {rsp_rdata, pwdata_o}, 64'd0);
    reset = 1'b1; pready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_reset_quiet", 64'({rsp_valid, psel_o}), 64'd0);
    end
    pready_i = 1'b0;

    // stalled slave
`ifdef APB_MASTER_TIMEOUT_EN
    xfer(1'b0, 4'h9, 32'h0, 100000, 1'b0, 1'b0, 120, got, lat, rd, er);
    chk("timeout_got", 64'(got), 64'd1);
    chk("timeout_lat", 64'(lat), 64'd18);
    chk("timeout_err", 64'(er), 64'd1);
    chk("timeout_rdata", 64'(rd), 64'd0);
`else
    xfer(1'b0, 4'h9, 32'h0, 100000, 1'b0, 1'b0, 100, got, lat, rd, er);
    chk("no_timeout_got", 64'(got), 64'd0);
    chk("no_timeout_waiting", 64'({psel_o, penable_o, rsp_err}), 64'd6);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
`endif
    @(posedge clk); #1;

    // randomized back-to-back writes with cmd_valid held, then readback of every address
    for (int i = 0; i < 16; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end
    c0 = rsp_cnt;
    for (int i = 0; i < 10; i++) begin
      a = 4'($urandom); d = $urandom; w = $urandom_range(0, 10);
      ref_mem[a] = d;
      xfer(1'b1, a, d, w, 1'($urandom), 1'b1, 50, got, lat, rd, er);
      chk("burst_got", 64'(got), 64'd1);
      chk("burst_lat", 64'(lat), 64'(3 + w));
      chk("burst_rdata", 64'(rd), 64'd0);
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("burst_rsp_count", 64'(rsp_cnt - c0), 64'd10);
    chk("burst_idle", 64'({psel_o, cmd_ready}), 64'd1);
    for (int i = 0; i < 16; i++) begin
      w = $urandom_range(0, 3);
      xfer(1'b0, 4'(i), $urandom, w, 1'b0, 1'b0, 50, got, lat, rd, er);
      chk($sformatf("readback%0d", i), 64'(rd), 64'(ref_mem[i]));
      chk("readback_lat", 64'(lat), 64'(3 + w));
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
